// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encoding and parity mode codes.
// Used by both the transmitter and the serial receiver.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  function automatic logic [7:0] data_mask(input int len);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a 1-bit async input.
// Resets to 1 so an idle-high line never looks like an edge.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_serial.sv
// Oversampling UART receiver: recovers frames from an async line
// with only the local clock; mid-bit sampling from the start edge.
`timescale 1ns/1ps
module uart_rx_serial
  import uart_defs::*;
#(
  parameter int Data_length  = 8,
  parameter bit parity_en    = 1'b0,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk2,
  input  logic       rst,
  input  logic       serialdata_in,
  input  logic       parity_type,
  output logic [7:0] parallel_dataout,
  output logic       rx_done,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]    IDX_LAST = 3'(Data_length - 1);
  localparam logic [7:0]    DMASK    = data_mask(Data_length);

  logic rx_s;
  logic rx_q;

  uart_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    sh_q, sh_d;
  logic          perr_q, perr_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          perr_o_q, perr_o_d;
  logic          ferr_q, ferr_d;

  sync_2ff u_sync (
    .clk   (clk2),
    .rst_n (rst),
    .d     (serialdata_in),
    .q     (rx_s)
  );

  always_ff @(posedge clk2 or negedge rst) begin
    if (!rst) begin
      rx_q     <= 1'b1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      perr_q   <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_q     <= rx_s;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      perr_q   <= perr_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      perr_o_q <= perr_o_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    perr_d   = perr_q;
    dout_d   = dout_q;
    done_d   = 1'b0;
    perr_o_d = perr_o_q;
    ferr_d   = ferr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_q && !rx_s) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          // Line back high at mid-start means a glitch, not a frame
          if (!rx_s) begin
            state_d = ST_DATA;
            idx_d   = '0;
            sh_d    = '0;
            perr_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d       = '0;
          sh_d[idx_q] = rx_s;
          if (idx_q == IDX_LAST) begin
            state_d = parity_en ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d   = '0;
          perr_d  = ((^(sh_q & DMASK)) ^ rx_s) != parity_type;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_MAX) begin
          cnt_d    = '0;
          state_d  = ST_IDLE;
          done_d   = 1'b1;
          dout_d   = sh_q & DMASK;
          perr_o_d = parity_en && perr_q;
          ferr_d   = ~rx_s;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign parallel_dataout = dout_q;
  assign rx_done          = done_q;
  assign parity_error     = perr_o_q;
  assign framing_error    = ferr_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_serial.sv
// Directed bench for uart_rx_serial: one instance without parity,
// one with parity, driven from separate serial lines.
`timescale 1ns/1ps
module tb_uart_rx_serial;

  logic clk2 = 1'b0;
  logic rst  = 1'b0;
  logic ln0  = 1'b1;
  logic ln1  = 1'b1;
  logic ptype = 1'b0;

  logic [7:0] dout0, dout1;
  logic done0, perr0, ferr0, busy0;
  logic done1, perr1, ferr1, busy1;

  int passed = 0;
  int total  = 0;
  int cycle  = 0;
  int t0     = 0;
  int n1     = 0;
  logic [9:0] q0[$];

  always #5 clk2 = ~clk2;

  uart_rx_serial #(
    .Data_length  (8),
    .parity_en    (1'b0),
    .CLKS_PER_BIT (16)
  ) dut0 (
    .clk2             (clk2),
    .rst              (rst),
    .serialdata_in    (ln0),
    .parity_type      (ptype),
    .parallel_dataout (dout0),
    .rx_done          (done0),
    .parity_error     (perr0),
    .framing_error    (ferr0),
    .busy             (busy0)
  );

  uart_rx_serial #(
    .Data_length  (8),
    .parity_en    (1'b1),
    .CLKS_PER_BIT (16)
  ) dut1 (
    .clk2             (clk2),
    .rst              (rst),
    .serialdata_in    (ln1),
    .parity_type      (ptype),
    .parallel_dataout (dout1),
    .rx_done          (done1),
    .parity_error     (perr1),
    .framing_error    (ferr1),
    .busy             (busy1)
  );

  always @(posedge clk2) cycle <= cycle + 1;

  always @(negedge clk2) begin
    if (done0) begin
      q0.push_back({perr0, ferr0, dout0});
      t0 = cycle;
    end
    if (done1) n1++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: sim time %0t exceeded bound", $time);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic send(input int sel, input logic [7:0] data,
                      input logic par, input logic stp,
                      input int bit_ns);
    logic [10:0] f;
    int n;
    n = (sel == 1) ? 11 : 10;
    f = (sel == 1) ? {stp, par, data, 1'b0}
                   : {1'b0, stp, data, 1'b0};
    for (int i = 0; i < n; i++) begin
      if (sel == 1) ln1 = f[i];
      else ln0 = f[i];
      #(bit_ns);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk2);
  endtask

  initial begin
    int st;
    int c;
    idle(3);
    chk("rst_dout", {24'd0, dout0}, 32'h0);
    chk("rst_flags", {done0, perr0, ferr0, busy0}, 4'b0000);
    chk("rst_flags1", {done1, perr1, ferr1, busy1}, 4'b0000);
    rst = 1'b1;
    idle(10);

    // clean frame + latency
    st = cycle;
    send(0, 8'hA5, 1'b0, 1'b1, 160);
    idle(20);
    chk("clean_cnt", q0.size(), 1);
    chk("clean_data", {22'd0, q0[0]}, {22'd0, 2'b00, 8'hA5});
    chk("clean_lat", t0 - st, 155);
    chk("clean_busy", {31'd0, busy0}, 32'd0);

    // parity: even, 0x3C has even weight
    ptype = 1'b0;
    send(1, 8'h3C, 1'b1, 1'b1, 160);
    idle(20);
    chk("par_cnt", n1, 1);
    chk("par_bad", {dout1, perr1, ferr1}, {8'h3C, 1'b1, 1'b0});
    send(1, 8'h3C, 1'b0, 1'b1, 160);
    idle(20);
    chk("par_good", {dout1, perr1, ferr1}, {8'h3C, 1'b0, 1'b0});
    ptype = 1'b1;
    send(1, 8'h3C, 1'b1, 1'b1, 160);
    idle(20);
    chk("par_odd", {n1, dout1, perr1}, {32'd3, 8'h3C, 1'b0});
    ptype = 1'b0;

    // framing error, line left low
    send(0, 8'h55, 1'b0, 1'b0, 160);
    idle(5);
    chk("frm_cnt", q0.size(), 2);
    chk("frm_data", {22'd0, q0[1]}, {22'd0, 2'b01, 8'h55});
    idle(200);
    chk("frm_hold", q0.size(), 2);
    ln0 = 1'b1;
    idle(30);
    send(0, 8'h12, 1'b0, 1'b1, 160);
    idle(20);
    chk("frm_next", {22'd0, q0[$]}, {22'd0, 2'b00, 8'h12});
    chk("frm_next_cnt", q0.size(), 3);

    // glitch of 4 cycles
    ln0 = 1'b0;
    idle(4);
    ln0 = 1'b1;
    idle(1);
    chk("gl_busy", {31'd0, busy0}, 32'd1);
    idle(7);
    chk("gl_idle", {31'd0, busy0}, 32'd0);
    idle(200);
    chk("gl_nodone", q0.size(), 3);

    // back-to-back, nominal and skewed
    send(0, 8'h00, 1'b0, 1'b1, 160);
    send(0, 8'hFF, 1'b0, 1'b1, 160);
    idle(20);
    chk("b2b_cnt", q0.size(), 5);
    chk("b2b_0", {22'd0, q0[3]}, {22'd0, 2'b00, 8'h00});
    chk("b2b_1", {22'd0, q0[4]}, {22'd0, 2'b00, 8'hFF});
    send(0, 8'h00, 1'b0, 1'b1, 155);
    send(0, 8'hFF, 1'b0, 1'b1, 155);
    idle(20);
    chk("fast_cnt", q0.size(), 7);
    chk("fast_0", {22'd0, q0[5]}, {22'd0, 2'b00, 8'h00});
    chk("fast_1", {22'd0, q0[6]}, {22'd0, 2'b00, 8'hFF});
    send(0, 8'h00, 1'b0, 1'b1, 165);
    send(0, 8'hFF, 1'b0, 1'b1, 165);
    idle(20);
    chk("slow_cnt", q0.size(), 9);
    chk("slow_0", {22'd0, q0[7]}, {22'd0, 2'b00, 8'h00});
    chk("slow_1", {22'd0, q0[8]}, {22'd0, 2'b00, 8'hFF});

    // reset during data bit 4
    c = q0.size();
    fork
      send(0, 8'h81, 1'b0, 1'b1, 160);
      begin
        #880;
        rst = 1'b0;
        #1;
        chk("rst_mid_dout", {24'd0, dout0}, 32'h0);
        chk("rst_mid_flg", {done0, perr0, ferr0, busy0}, 4'b0000);
        #600;
        rst = 1'b1;
      end
    join
    idle(20);
    chk("rst_mid_cnt", q0.size(), c);
    send(0, 8'h81, 1'b0, 1'b1, 160);
    idle(20);
    chk("rst_after_cnt", q0.size(), c + 1);
    chk("rst_after", {22'd0, q0[$]}, {22'd0, 2'b00, 8'h81});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_serial.md
# uart_rx_serial

Standalone UART receiver that recovers frames from an asynchronous serial line using only its local clock: no `tx_done` side-channel, no shared transmitter clock. It is the far-end counterpart of the `Transmitter` and sits at chip pins or inter-board links. Its output (`parallel_dataout`, `rx_done`, error flags) matches the existing `Receiver`, so `UART_TOPMODULE`-style wrappers can swap it in.

## Interface
- `Data_length`, 8: data bits per frame, 5–8.
- `parity_en`, 0: 1 means a parity bit follows the data bits.
- `CLKS_PER_BIT`, 16: `clk2` cycles per bit period. Must be even and ≥ 4.
- `clk2` in 1: receiver clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `serialdata_in` in 1: asynchronous serial line. Idle level is high.
- `parity_type` in 1: 0 = even, 1 = odd. Sampled when the parity bit is checked.
- `parallel_dataout` out 8: last received data. Held until the next `rx_done`.
- `rx_done` out 1: one-cycle pulse when a frame completes.
- `parity_error` out 1: valid with `rx_done`. Held until the next `rx_done`.
- `framing_error` out 1: valid with `rx_done`. Held until the next `rx_done`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `serialdata_in` passes through a 2-flop synchronizer, giving `rx_s`. A third flop gives `rx_q`, the previous value of `rx_s`.
- Frame format, LSB first: start (0), `Data_length` data bits, optional parity bit, one stop bit (1).
- States are IDLE, START, DATA, PARITY, STOP. A counter `cnt` runs 0..CLKS_PER_BIT-1. A bit index `idx` runs 0..Data_length-1.
- **IDLE:** if `rx_q`=1 and `rx_s`=0 (falling edge), go to START with `cnt`=0. A line held low does not retrigger; a new frame needs a high-to-low edge.
- **START:** at `cnt`=CLKS_PER_BIT/2-1, sample `rx_s`.
  - 0: go to DATA with `cnt`=0 and `idx`=0.
  - 1: false start; return to IDLE with no pulse and no flag change.
- **DATA:** at `cnt`=CLKS_PER_BIT-1, shift `rx_s` into the shift register at position `idx` and reset `cnt` to 0.
  - After bit `Data_length-1`, go to PARITY if `parity_en`=1, otherwise to STOP.
  - Each sample falls mid-bit.
- **PARITY:** at `cnt`=CLKS_PER_BIT-1, check the sampled bit against the received data bits.
  - Even mode: the XOR of data bits and parity bit must be 0.
  - Odd mode: it must be 1.
  - A mismatch sets the internal parity flag.
  - Go to STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT-1, sample `rx_s`; 0 is a framing error. Then, on the next edge:
  - pulse `rx_done`;
  - load `parallel_dataout` (bits ≥ Data_length are forced to 0);
  - load `parity_error` (always 0 when `parity_en`=0) and `framing_error`;
  - return to IDLE.
- Errors do not suppress `rx_done` or the data update.

## Timing
- Reset values: all outputs 0; state IDLE; `cnt`=0; `idx`=0; `rx_s` and `rx_q` = 1.
- Reset mid-frame aborts the frame immediately, with no `rx_done`. After release, the block waits for a fresh falling edge.
- Start-to-done latency: `rx_done` rises 2 + 1 + CLKS_PER_BIT/2 + (Data_length + parity_en + 1)·CLKS_PER_BIT cycles after the line falls. The terms are synchronizer, edge detect, and bit sampling.
- Back-to-back frames: STOP returns to IDLE about CLKS_PER_BIT/2 before the nominal end of the stop bit. A start edge arriving immediately after the stop bit is therefore caught.
- Glitches shorter than CLKS_PER_BIT/2 cycles are rejected at the START check.
- There is no handshake and no buffering. A consumer that misses `rx_done` loses the frame; the previous value is overwritten.
- `parity_type` changing mid-frame affects only the PARITY check.

## Structure
- Shared package or header `uart_defs`:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3 bits);
  - `PARITY_EVEN`=0 and `PARITY_ODD`=1;
  - used by both `Transmitter` and this block.
- One sub-module, `sync_2ff` (1-bit, reset-to-1 synchronizer). It is reusable for other async inputs.
- The counter, FSM, shift register and output registers live in the top module.

## Test plan
Conditions for all cases unless stated: CLKS_PER_BIT=16, Data_length=8.
- **Clean frame:** parity_en=0, send 0xA5. Expect one `rx_done` pulse, `parallel_dataout`=0xA5, both error flags 0, and `rx_done` at the computed latency (2+1+8+9·16 cycles).
- **Parity error:** parity_en=1, parity_type=0, send 0x3C with parity bit 1. Expect data 0x3C, `parity_error`=1, `framing_error`=0. Resend with parity bit 0: `parity_error`=0.
- **Framing error:** send 0x55 with the stop bit driven 0. Expect `rx_done`, data 0x55, `framing_error`=1. Hold the line low afterward and confirm no further `rx_done` until the line goes high and then falls again.
- **Glitch:** drive a 4-cycle low pulse on an idle line. Expect no `rx_done` and `busy` back to 0 within 12 cycles.
- **Back-to-back:** send 0x00 then 0xFF with zero idle gap. Expect two pulses with data 0x00 then 0xFF and no errors. Repeat with the bit period skewed ±3% and expect the same.
- **Reset mid-frame:** assert `rst` low during DATA bit 4 of a 0x81 frame. Expect all outputs 0 immediately and no pulse. The next full 0x81 frame is received correctly.
